// File: rtl/vx_mem_pending_limiter_if.sv
// Memory request/response bus shared by the core side and the L2/memory side
// of vx_mem_pending_limiter. The master drives requests and accepts responses.
interface vx_mem_pending_limiter_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                    req_valid;
    logic                    req_rw;
    logic [DATA_WIDTH/8-1:0] req_byteen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    req_ready;

    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/vx_mem_pending_limiter.sv
// vx_mem_pending_limiter: 2-entry registered request FIFO between the core
// memory port and L2/memory, with a cap of MAX_PENDING outstanding reads.
// Responses pass straight through. Reads reserve a pending slot at accept time,
// so reads still parked in the FIFO are already counted.
// Optional feature macro: VX_MEM_LIMITER_PERF_EN adds stall-cycle and
// peak-pending performance counters.
// The reset input is expected to be deasserted synchronously to clk upstream.
module vx_mem_pending_limiter #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 26,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_mem_pending_limiter_if.slave  core_if,
    vx_mem_pending_limiter_if.master mem_if,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  busy
`ifdef VX_MEM_LIMITER_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_peak_pending
`endif
);
    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);

    typedef struct packed {
        logic                    rw;
        logic [DATA_WIDTH/8-1:0] byteen;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [TAG_WIDTH-1:0]    tag;
    } req_t;

    req_t             fifo_q [2];
    req_t             fifo_d [2];
    req_t             in_req;
    req_t             head;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] pending_q, pending_d;

    logic fifo_full, fifo_empty, push, pop, rd_fire, rsp_fire;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);

    // Ready ignores a same-cycle pop; with two entries this still sustains one
    // request per cycle because steady streaming keeps only one entry occupied.
    // Gated by reset so nothing is accepted while reset is held.
    assign core_if.req_ready = reset && !fifo_full && (core_if.req_rw || (pending_q < MAX_P));

    assign push     = core_if.req_valid && core_if.req_ready;
    assign pop      = mem_if.req_valid && mem_if.req_ready;
    assign rd_fire  = push && !core_if.req_rw;
    assign rsp_fire = mem_if.rsp_valid && core_if.rsp_ready;

    assign in_req = '{rw: core_if.req_rw, byteen: core_if.req_byteen, addr: core_if.req_addr,
                      data: core_if.req_data, tag: core_if.req_tag};
    assign head   = fifo_q[rd_ptr_q];

    assign mem_if.req_valid  = !fifo_empty;
    assign mem_if.req_rw     = head.rw;
    assign mem_if.req_byteen = head.byteen;
    assign mem_if.req_addr   = head.addr;
    assign mem_if.req_data   = head.data;
    assign mem_if.req_tag    = head.tag;

    assign core_if.rsp_valid = mem_if.rsp_valid;
    assign core_if.rsp_data  = mem_if.rsp_data;
    assign core_if.rsp_tag   = mem_if.rsp_tag;
    assign mem_if.rsp_ready  = core_if.rsp_ready;

    assign pending_count = pending_q;
    assign busy          = (pending_q != '0) || !fifo_empty;

    // Next-state for FIFO pointers/occupancy/storage and the read reservation count.
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + 2'(push) - 2'(pop);
        pending_d = pending_q;
        if (push) begin
            fifo_d[wr_ptr_q] = in_req;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        if (rd_fire && !rsp_fire)
            pending_d = pending_q + 1'b1;
        else if (!rd_fire && rsp_fire && (pending_q != '0))
            pending_d = pending_q - 1'b1;
    end

    // Control state; reset discards buffered requests and in-flight accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Payload storage needs no reset; occupancy qualifies it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

`ifdef VX_MEM_LIMITER_PERF_EN
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] peak_pending_q, peak_pending_d;

    // Stall counter wraps naturally; peak tracks the registered pending count.
    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(core_if.req_valid && !core_if.req_ready);
        peak_pending_d = (pending_q > peak_pending_q) ? pending_q : peak_pending_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            peak_pending_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            peak_pending_q <= peak_pending_d;
        end
    end

    assign perf_stall_cycles = stall_cycles_q;
    assign perf_peak_pending = peak_pending_q;
`endif

`ifndef SYNTHESIS
    // Protocol sanity: responses without an outstanding read, and count bound.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(rsp_fire && (pending_q == '0)))
                else $warning("vx_mem_pending_limiter: response with no outstanding read");
            assert (pending_q <= MAX_P)
                else $error("vx_mem_pending_limiter: pending_count above MAX_PENDING");
        end
    end
`endif
endmodule

// File: tb/tb_vx_mem_pending_limiter.sv
// Directed bench for vx_mem_pending_limiter with MAX_PENDING=4.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_vx_mem_pending_limiter;
    localparam int DW = 32, AW = 8, TW = 4, MP = 4, CW = $clog2(MP + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [CW-1:0] pending_count;
    logic busy;
`ifdef VX_MEM_LIMITER_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [CW-1:0] perf_peak_pending;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_mem_pending_limiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) core_if ();
    vx_mem_pending_limiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) mem_if ();

    vx_mem_pending_limiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset), .core_if(core_if), .mem_if(mem_if),
        .pending_count(pending_count), .busy(busy)
`ifdef VX_MEM_LIMITER_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_peak_pending(perf_peak_pending)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic rw, input logic [TW-1:0] tag);
        core_if.req_valid  = v;
        core_if.req_rw     = rw;
        core_if.req_tag    = tag;
        core_if.req_addr   = AW'(tag) + 8'h40;
        core_if.req_data   = {8{tag}};
        core_if.req_byteen = 4'hF;
    endtask

    task automatic test_reset();
        drive_req(1'b0, 1'b0, '0);
        core_if.rsp_ready = 1'b0;
        mem_if.req_ready  = 1'b0;
        mem_if.rsp_valid  = 1'b0;
        mem_if.rsp_data   = '0;
        mem_if.rsp_tag    = '0;
        repeat (3) cyc();
        checks++; if (core_if.req_ready !== 1'b0) begin failures++; $display("FAIL rst_held_ready got=%0b exp=0", core_if.req_ready); end
        checks++; if (mem_if.req_valid !== 1'b0) begin failures++; $display("FAIL rst_held_memvalid got=%0b exp=0", mem_if.req_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_held_busy got=%0b exp=0", busy); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL rst_held_pending got=%0d exp=0", pending_count); end
        reset = 1'b1;
        #1;
        checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_ready got=%0b exp=1", core_if.req_ready); end
        checks++; if (core_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rel_rspvalid got=%0b exp=0", core_if.rsp_valid); end
        cyc();
        checks++; if (busy !== 1'b0 || pending_count !== 3'd0 || mem_if.req_valid !== 1'b0) begin
            failures++; $display("FAIL idle_state got busy=%0b pend=%0d mv=%0b exp 0 0 0", busy, pending_count, mem_if.req_valid); end
    endtask

    task automatic test_overflow();
        mem_if.req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b0, TW'(i));
            #1;
            checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL ovf_accept%0d got=%0b exp=1", i, core_if.req_ready); end
            cyc();
        end
        drive_req(1'b1, 1'b0, 4'd4);
        #1;
        checks++; if (core_if.req_ready !== 1'b0) begin failures++; $display("FAIL ovf_fifth_held got=%0b exp=0", core_if.req_ready); end
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL ovf_pending got=%0d exp=4", pending_count); end
        cyc(); cyc();
        checks++; if (core_if.req_ready !== 1'b0) begin failures++; $display("FAIL ovf_still_held got=%0b exp=0", core_if.req_ready); end
        // One response: pass-through visible, but no same-cycle bypass for the read.
        core_if.rsp_ready = 1'b1;
        mem_if.rsp_valid  = 1'b1;
        mem_if.rsp_tag    = 4'd0;
        mem_if.rsp_data   = 32'hCAFE_0000;
        #1;
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_tag !== 4'd0 || core_if.rsp_data !== 32'hCAFE_0000) begin
            failures++; $display("FAIL rsp_pass got v=%0b t=%0h d=%0h exp 1 0 cafe0000", core_if.rsp_valid, core_if.rsp_tag, core_if.rsp_data); end
        checks++; if (core_if.req_ready !== 1'b0) begin failures++; $display("FAIL no_bypass got=%0b exp=0", core_if.req_ready); end
        cyc();
        mem_if.rsp_valid = 1'b0;
        #1;
        checks++; if (core_if.req_ready !== 1'b1 || pending_count !== 3'd3) begin
            failures++; $display("FAIL ovf_after_rsp got rdy=%0b pend=%0d exp 1 3", core_if.req_ready, pending_count); end
        cyc();
        drive_req(1'b0, 1'b0, '0);
        checks++; if (mem_if.req_valid !== 1'b1 || mem_if.req_tag !== 4'd4 || pending_count !== 3'd4) begin
            failures++; $display("FAIL ovf_fifth_issued got mv=%0b tag=%0d pend=%0d exp 1 4 4", mem_if.req_valid, mem_if.req_tag, pending_count); end
        cyc();
`ifdef VX_MEM_LIMITER_PERF_EN
        checks++; if (perf_peak_pending !== 3'd4) begin failures++; $display("FAIL perf_peak got=%0d exp=4", perf_peak_pending); end
`endif
    endtask

    task automatic test_writes_at_limit();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 1'b1, TW'(8 + i));
            #1;
            checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL wr_accept%0d got=%0b exp=1", i, core_if.req_ready); end
            cyc();
            checks++; if (mem_if.req_valid !== 1'b1 || mem_if.req_rw !== 1'b1 || mem_if.req_tag !== TW'(8 + i) || pending_count !== 3'd4) begin
                failures++; $display("FAIL wr_issue%0d got mv=%0b rw=%0b tag=%0d pend=%0d exp 1 1 %0d 4",
                                     i, mem_if.req_valid, mem_if.req_rw, mem_if.req_tag, pending_count, 8 + i); end
        end
        drive_req(1'b0, 1'b0, '0);
        cyc();
        checks++; if (mem_if.req_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL wr_drained got mv=%0b busy=%0b exp 0 1", mem_if.req_valid, busy); end
        mem_if.rsp_valid = 1'b1;
        repeat (4) cyc();
        mem_if.rsp_valid = 1'b0;
        #1;
        checks++; if (pending_count !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL all_rsp got pend=%0d busy=%0b exp 0 0", pending_count, busy); end
    endtask

    task automatic test_backpressure();
        mem_if.req_ready = 1'b0;
        drive_req(1'b1, 1'b0, 4'd0);
        #1;
        checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL bp_acc0 got=%0b exp=1", core_if.req_ready); end
        cyc();
        drive_req(1'b1, 1'b0, 4'd1);
        #1;
        checks++; if (core_if.req_ready !== 1'b1 || mem_if.req_valid !== 1'b1 || mem_if.req_tag !== 4'd0) begin
            failures++; $display("FAIL bp_acc1 got rdy=%0b mv=%0b tag=%0d exp 1 1 0", core_if.req_ready, mem_if.req_valid, mem_if.req_tag); end
        cyc();
        drive_req(1'b1, 1'b0, 4'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (core_if.req_ready !== 1'b0 || mem_if.req_tag !== 4'd0 || mem_if.req_addr !== 8'h40) begin
                failures++; $display("FAIL bp_full%0d got rdy=%0b tag=%0d addr=%0h exp 0 0 40", k, core_if.req_ready, mem_if.req_tag, mem_if.req_addr); end
            cyc();
        end
        drive_req(1'b0, 1'b0, '0);
        mem_if.req_ready = 1'b1;
        #1;
        checks++; if (mem_if.req_valid !== 1'b1 || mem_if.req_tag !== 4'd0) begin failures++; $display("FAIL bp_drain0 got tag=%0d exp=0", mem_if.req_tag); end
        cyc();
        checks++; if (mem_if.req_valid !== 1'b1 || mem_if.req_tag !== 4'd1) begin failures++; $display("FAIL bp_drain1 got tag=%0d exp=1", mem_if.req_tag); end
        cyc();
        checks++; if (mem_if.req_valid !== 1'b0 || pending_count !== 3'd2) begin
            failures++; $display("FAIL bp_empty got mv=%0b pend=%0d exp 0 2", mem_if.req_valid, pending_count); end
    endtask

    task automatic test_simultaneous();
        drive_req(1'b1, 1'b0, 4'd5);
        mem_if.rsp_valid = 1'b1;
        #1;
        checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%0b exp=1", core_if.req_ready); end
        cyc();
        drive_req(1'b0, 1'b0, '0);
        mem_if.rsp_valid = 1'b0;
        #1;
        checks++; if (pending_count !== 3'd2) begin failures++; $display("FAIL sim_count got=%0d exp=2", pending_count); end
        cyc();
        mem_if.rsp_valid = 1'b1;
        cyc(); cyc();
        mem_if.rsp_valid = 1'b0;
        #1;
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL sim_drain got=%0d exp=0", pending_count); end
    endtask

    task automatic test_underflow();
        core_if.rsp_ready = 1'b0;
        mem_if.rsp_valid  = 1'b1;
        #1;
        checks++; if (mem_if.rsp_ready !== 1'b0) begin failures++; $display("FAIL rsp_ready_pass got=%0b exp=0", mem_if.rsp_ready); end
        core_if.rsp_ready = 1'b1;
        #1;
        checks++; if (mem_if.rsp_ready !== 1'b1) begin failures++; $display("FAIL rsp_ready_pass1 got=%0b exp=1", mem_if.rsp_ready); end
        cyc();
        mem_if.rsp_valid = 1'b0;
        #1;
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL underflow got=%0d exp=0", pending_count); end
    endtask

    task automatic test_reset_mid();
        mem_if.req_ready = 1'b0;
        drive_req(1'b1, 1'b0, 4'd1);
        cyc(); cyc();
        checks++; if (pending_count !== 3'd2) begin failures++; $display("FAIL mid_setup got=%0d exp=2", pending_count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pending_count !== 3'd0 || mem_if.req_valid !== 1'b0 || core_if.req_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset got pend=%0d mv=%0b rdy=%0b busy=%0b exp 0 0 0 0",
                                 pending_count, mem_if.req_valid, core_if.req_ready, busy); end
        drive_req(1'b0, 1'b0, '0);
        cyc();
        reset = 1'b1;
        #1;
        checks++; if (core_if.req_ready !== 1'b1 || mem_if.req_valid !== 1'b0) begin
            failures++; $display("FAIL mid_release got rdy=%0b mv=%0b exp 1 0", core_if.req_ready, mem_if.req_valid); end
        cyc();
    endtask

`ifdef VX_MEM_LIMITER_PERF_EN
    task automatic test_perf_stall();
        mem_if.req_ready = 1'b0;
        checks++; if (perf_stall_cycles !== 32'd0 || perf_peak_pending !== 3'd0) begin
            failures++; $display("FAIL perf_reset got st=%0d pk=%0d exp 0 0", perf_stall_cycles, perf_peak_pending); end
        drive_req(1'b1, 1'b1, 4'd3);
        cyc(); cyc();
        repeat (7) cyc();
        drive_req(1'b0, 1'b0, '0);
        #1;
        checks++; if (perf_stall_cycles !== 32'd7) begin failures++; $display("FAIL perf_stall got=%0d exp=7", perf_stall_cycles); end
        mem_if.req_ready = 1'b1;
        cyc(); cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_overflow();
        test_writes_at_limit();
        test_backpressure();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
`ifdef VX_MEM_LIMITER_PERF_EN
        test_perf_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
